// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser followed by a level debounce filter; idles high.
module ps2_sync_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive samples that disagree with the filtered level.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], din};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: frames 11-bit packets, folds E0/F0 prefixes into
// key events and queues them in a show-ahead FIFO.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  input  logic                        rd_en,
  input  logic                        clr_overflow,
  output logic                        evt_valid,
  output logic [7:0]                  evt_code,
  output logic                        evt_break,
  output logic                        evt_ext,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        frame_err
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic clk_f, data_f, clk_prev_q, sample_edge;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk    (clk),
    .resetn (resetn),
    .din    (ps2_clk),
    .dout   (clk_f)
  );

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk    (clk),
    .resetn (resetn),
    .din    (ps2_data),
    .dout   (data_f)
  );

  assign sample_edge = clk_prev_q & ~clk_f;

  ps2_state_e    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic          push_q, push_d, frame_err_q, frame_err_d;
  ps2_evt_t      push_evt_q, push_evt_d;
  logic          byte_done, err;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    to_cnt_d   = to_cnt_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    push_d     = 1'b0;
    push_evt_d = push_evt_q;
    byte_done  = 1'b0;
    err        = 1'b0;

    if (state_q != StIdle) to_cnt_d = to_cnt_q + TW'(1);

    if (sample_edge) begin
      to_cnt_d = '0;
      unique case (state_q)
        StIdle: begin
          // A high data line at a clock edge is a false start.
          if (!data_f) begin
            state_d = StData;
            idx_d   = 3'd0;
          end
        end
        StData: begin
          shift_d[idx_q] = data_f;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_d   = data_f;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (data_f && (^{shift_q, par_q})) byte_done = 1'b1;
          else                               err       = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end else if ((state_q != StIdle) && (to_cnt_q == TW'(TIMEOUT_CYC - 1))) begin
      err      = 1'b1;
      state_d  = StIdle;
      to_cnt_d = '0;
    end

    if (err) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end

    if (byte_done) begin
      if (shift_q == PS2_PREFIX_EXT) begin
        ext_pend_d = 1'b1;
      end else if (shift_q == PS2_PREFIX_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        push_d     = 1'b1;
        push_evt_d = '{ext: ext_pend_q, brk: brk_pend_q, code: shift_q};
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end

    frame_err_d = err;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_prev_q  <= 1'b1;
      state_q     <= StIdle;
      idx_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      push_q      <= 1'b0;
      push_evt_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      clk_prev_q  <= clk_f;
      state_q     <= state_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      push_q      <= push_d;
      push_evt_q  <= push_evt_d;
      frame_err_q <= frame_err_d;
    end
  end

  ps2_evt_t          mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              empty, full, do_pop, do_wr, drop;
  ps2_evt_t          head;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign do_pop = rd_en & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_wr  = push_q & (~full | do_pop);
  assign drop   = push_q & full & ~do_pop;

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_wr && do_pop) count_d = count_q - CW'(1);
    overflow_d = overflow_q;
    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_wr)  wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= push_evt_q;
  end

  assign head       = mem[rd_ptr_q];
  assign evt_valid  = ~empty;
  assign evt_code   = empty ? 8'h00 : head.code;
  assign evt_break  = ~empty & head.brk;
  assign evt_ext    = ~empty & head.ext;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: decoding, prefixes, errors, FIFO limits.
module tb_ps2_scan_rx;

  localparam int HALF    = 20;   // clk cycles per PS/2 clock half-period
  localparam int TIMEOUT = 500;

  logic       clk = 1'b0;
  logic       resetn, ps2_clk, ps2_data, rd_en, clr_overflow;
  logic       evt_valid, evt_break, evt_ext, overflow, frame_err;
  logic [7:0] evt_code;
  logic [3:0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;
  int err_pulses = 0;
  int err_wide = 0;
  logic err_prev = 1'b0;

  always #10 clk = ~clk;

  ps2_scan_rx #(
    .FIFO_DEPTH  (8),
    .FILTER_LEN  (4),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .rd_en        (rd_en),
    .clr_overflow (clr_overflow),
    .evt_valid    (evt_valid),
    .evt_code     (evt_code),
    .evt_break    (evt_break),
    .evt_ext      (evt_ext),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .frame_err    (frame_err)
  );

  always @(posedge clk) begin
    if (frame_err) err_pulses <= err_pulses + 1;
    if (frame_err && err_prev) err_wide <= err_wide + 1;
    err_prev <= frame_err;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed no finish, expected finish before 5 ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      repeat (5) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (2) @(posedge clk);
      #1 ps2_clk = 1'b1;
      repeat (HALF - 7) @(posedge clk);
    end else begin
      repeat (HALF) @(posedge clk);
    end
    #1 ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  // Start bit plus the first nbits data bits.
  task automatic send_partial(input logic [7:0] b, input int nbits, input int glitch_at);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(b[i], i == glitch_at);
  endtask

  task automatic send_head(input logic [7:0] b, input bit bad_par, input int glitch_at);
    send_partial(b, 8, glitch_at);
    send_bit((~^b) ^ bad_par, 1'b0);
  endtask

  // Leaves ps2_clk falling 1 time unit after a clk posedge.
  task automatic stop_fall();
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
  endtask

  task automatic stop_rise();
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (2 * HALF) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    send_head(b, bad_par, -1);
    stop_fall();
    stop_rise();
  endtask

  task automatic pop();
    @(posedge clk);
    #1 rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int base;
    logic [7:0] exp_code;

    resetn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; clr_overflow = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_valid", evt_valid, 0);
    check("rst_code", evt_code, 0);
    check("rst_brk", evt_break, 0);
    check("rst_ext", evt_ext, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ferr", frame_err, 0);
    #1 resetn = 1'b1;
    repeat (10) @(posedge clk);

    // 2 sync + 4 filter + edge register + push register ahead of evt_valid.
    send_head(8'h1C, 1'b0, -1);
    stop_fall();
    repeat (8) @(negedge clk);
    check("lat_pre", evt_valid, 0);
    @(negedge clk);
    check("lat_rise", evt_valid, 1);
    stop_rise();
    check("f1c_code", evt_code, 8'h1C);
    check("f1c_brk", evt_break, 0);
    check("f1c_ext", evt_ext, 0);
    check("f1c_count", fifo_count, 1);
    pop();
    check("f1c_pop_valid", evt_valid, 0);
    check("f1c_pop_count", fifo_count, 0);

    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    check("pfx_no_event", fifo_count, 0);
    send_frame(8'h75, 1'b0);
    check("e0f0_count", fifo_count, 1);
    check("e0f0_code", evt_code, 8'h75);
    check("e0f0_ext", evt_ext, 1);
    check("e0f0_brk", evt_break, 1);
    pop();

    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check("f0_code", evt_code, 8'h1C);
    check("f0_ext", evt_ext, 0);
    check("f0_brk", evt_break, 1);
    pop();

    send_frame(8'hF0, 1'b0);
    base = err_pulses;
    send_frame(8'h1C, 1'b1);
    check("par_err_pulse", err_pulses - base, 1);
    check("par_no_event", fifo_count, 0);
    send_frame(8'h32, 1'b0);
    check("par_next_code", evt_code, 8'h32);
    check("par_next_brk", evt_break, 0);
    pop();

    base = err_pulses;
    send_partial(8'h55, 4, -1);
    repeat (TIMEOUT + 100) @(posedge clk);
    @(negedge clk);
    check("to_err_pulse", err_pulses - base, 1);
    check("to_no_event", fifo_count, 0);
    send_frame(8'h2A, 1'b0);
    check("to_next_count", fifo_count, 1);
    check("to_next_code", evt_code, 8'h2A);
    check("to_next_flags", {evt_ext, evt_break}, 0);
    pop();

    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b0);
    check("full_count", fifo_count, 8);
    check("full_ovf", overflow, 1);
    check("full_head", evt_code, 8'h10);
    @(posedge clk);
    #1 clr_overflow = 1'b1;
    @(posedge clk);
    #1 clr_overflow = 1'b0;
    @(negedge clk);
    check("clr_ovf", overflow, 0);
    check("clr_count", fifo_count, 8);

    // Pop lands in exactly the cycle the new event is pushed.
    send_head(8'h19, 1'b0, -1);
    stop_fall();
    repeat (7) @(posedge clk);
    #1 rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    stop_rise();
    check("pp_ovf", overflow, 0);
    check("pp_count", fifo_count, 8);
    check("pp_head", evt_code, 8'h11);
    for (int i = 0; i < 8; i++) begin
      exp_code = (i < 7) ? 8'h11 + 8'(i) : 8'h19;
      check("drain_code", evt_code, exp_code);
      pop();
    end
    check("drain_count", fifo_count, 0);
    check("drain_valid", evt_valid, 0);

    base = err_pulses;
    send_head(8'h5A, 1'b0, 3);
    stop_fall();
    stop_rise();
    check("glitch_count", fifo_count, 1);
    check("glitch_code", evt_code, 8'h5A);
    check("glitch_no_err", err_pulses - base, 0);
    pop();

    send_frame(8'h33, 1'b0);
    send_partial(8'h44, 3, -1);
    resetn = 1'b0;
    #1;
    check("mrst_valid", evt_valid, 0);
    check("mrst_count", fifo_count, 0);
    check("mrst_code", evt_code, 0);
    check("mrst_ferr", frame_err, 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (10) @(posedge clk);
    send_frame(8'h44, 1'b0);
    check("mrst_next_count", fifo_count, 1);
    check("mrst_next_code", evt_code, 8'h44);
    pop();

    check("ferr_width", err_wide, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
